// File: rtl/full_adder32_pkg.sv
// Shared sizing and the expanded group-lookahead carry for full_adder32.
package full_adder32_pkg;
  localparam int WIDTH       = 32;
  localparam int GROUP_W     = 4;
  localparam int N_GROUPS    = WIDTH / GROUP_W;
  localparam int HALF        = WIDTH / 2;
  localparam int HALF_GROUPS = HALF / GROUP_W;

  // Carry into group k of a half, in sum-of-products form:
  // OR_j ( GG[j] & PG[j+1..k-1] )  |  ( PG[0..k-1] & cin ).
  function automatic logic la_carry(input logic [HALF_GROUPS-1:0] gg,
                                    input logic [HALF_GROUPS-1:0] pg,
                                    input logic                   cin,
                                    input int                     k);
    logic c;
    logic term;
    c = 1'b0;
    for (int j = 0; j < k; j++) begin
      term = gg[j];
      for (int m = j + 1; m < k; m++) term = term & pg[m];
      c = c | term;
    end
    term = cin;
    for (int m = 0; m < k; m++) term = term & pg[m];
    return c | term;
  endfunction
endpackage

// File: rtl/full_adder32_cla4.sv
// 4-bit carry-lookahead group: sum plus group propagate/generate.
module full_adder32_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);
  logic [3:0] g, p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign pg  = &p;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/full_adder32.sv
// Registered 32-bit CLA adder, s = a + b mod 2^32.
// Define FULL_ADDER32_PIPE_EN for a two-stage (latency 2) split at bit 16.
module full_adder32
  import full_adder32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);
  logic [N_GROUPS-1:0][GROUP_W-1:0] grp_a, grp_b, grp_sum;
  logic [N_GROUPS-1:0]              grp_cin, grp_pg, grp_gg;
  logic [WIDTH-1:0]                 sum_flat;
  logic [HALF-1:0]                  hi_a, hi_b;
  logic                             c16, hi_cin;

  assign grp_a    = {hi_a, a[HALF-1:0]};
  assign grp_b    = {hi_b, b[HALF-1:0]};
  assign sum_flat = grp_sum;

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
    if (g < HALF_GROUPS) begin : g_lo
      assign grp_cin[g] = la_carry(grp_gg[HALF_GROUPS-1:0], grp_pg[HALF_GROUPS-1:0],
                                   1'b0, g);
    end else begin : g_hi
      assign grp_cin[g] = la_carry(grp_gg[N_GROUPS-1:HALF_GROUPS],
                                   grp_pg[N_GROUPS-1:HALF_GROUPS], hi_cin, g - HALF_GROUPS);
    end
    full_adder32_cla4 u_cla4 (
      .a   (grp_a[g]),
      .b   (grp_b[g]),
      .cin (grp_cin[g]),
      .sum (grp_sum[g]),
      .pg  (grp_pg[g]),
      .gg  (grp_gg[g])
    );
  end

  assign c16 = la_carry(grp_gg[HALF_GROUPS-1:0], grp_pg[HALF_GROUPS-1:0], 1'b0, HALF_GROUPS);

`ifdef FULL_ADDER32_PIPE_EN
  // Stage 1 holds the low half result, its carry-out and the untouched high operands.
  logic [HALF-1:0] lo_sum_q, a_hi_q, b_hi_q;
  logic            c16_q;

  assign hi_a   = a_hi_q;
  assign hi_b   = b_hi_q;
  assign hi_cin = c16_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_sum_q <= '0;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      c16_q    <= 1'b0;
      s        <= '0;
    end else begin
      lo_sum_q <= sum_flat[HALF-1:0];
      a_hi_q   <= a[WIDTH-1:HALF];
      b_hi_q   <= b[WIDTH-1:HALF];
      c16_q    <= c16;
      s        <= {sum_flat[WIDTH-1:HALF], lo_sum_q};
    end
  end
`else
  assign hi_a   = a[WIDTH-1:HALF];
  assign hi_b   = b[WIDTH-1:HALF];
  assign hi_cin = c16;

  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else     s <= sum_flat;
  end
`endif
endmodule

// File: tb/tb_full_adder32.sv
// Scoreboard bench for full_adder32; latency follows FULL_ADDER32_PIPE_EN.
module tb_full_adder32;
`ifdef FULL_ADDER32_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [31:0] s;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  full_adder32 dut (.clk(clk), .rst(rst), .a(a), .b(b), .s(s));

  always #5 clk = ~clk;

  // One clock: drive operands, model the edge, compare whatever result emerges.
  task automatic step(input logic [31:0] ai, input logic [31:0] bi, input logic ri,
                      input string tag);
    logic [31:0] exp;
    @(negedge clk);
    a = ai; b = bi; rst = ri;
    @(posedge clk);
    if (ri) for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '0;
    exp_q.push_back(ri ? 32'd0 : ai + bi);
    #1;
    if (exp_q.size() >= LAT) begin
      exp = exp_q.pop_front();
      checks++;
      assert (s === exp) else begin
        errors++;
        $error("FAIL %s: s=%h expected %h", tag, s, exp);
      end
    end
  endtask

  initial begin
    // Reset held two edges with live operands, then release.
    step(32'd1200, 32'd9999, 1'b1, "reset0");
    step(32'd1200, 32'd9999, 1'b1, "reset1");
    checks++;
    assert (s === 32'd0) else begin
      errors++;
      $error("FAIL reset_state: s=%h expected %h", s, 32'd0);
    end
    step(32'd1200, 32'd9999, 1'b0, "release");
    step(32'd1000000, 32'd1231233, 1'b0, "basic");
    step(32'd0, 32'd0, 1'b0, "zero");
    step(32'hFFFF_FFFF, 32'd1, 1'b0, "wrap_all_ones");
    step(32'h8000_0000, 32'h8000_0000, 1'b0, "wrap_msb");
    step(32'h0000_FFFF, 32'd1, 1'b0, "half_boundary");
    step(32'h0000_000F, 32'd1, 1'b0, "group_boundary");
    step(32'h7FFF_FFFF, 32'd1, 1'b0, "signed_ovf");
    step(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, "neg_plus_neg");
    step(32'h00FF_FFFF, 32'hFF00_0001, 1'b0, "full_chain");
    // Back-to-back random stream with a one-cycle reset in the middle.
    for (int i = 0; i < 1000; i++)
      step($urandom, $urandom, (i == 500), "random");
    for (int i = 0; i < LAT; i++)
      step(32'd0, 32'd0, 1'b0, "drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
